// File: rtl/wb_retire_buffer_if.sv
// MEM-to-WB entry handshake for the retire buffer.
// MEM drives one entry per cycle; the buffer answers with in_ready.
interface wb_retire_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic            in_gr_we;
  logic [4:0]      in_dest;
  logic [XLEN-1:0] in_result;
  logic            in_csr_we;
  logic [13:0]     in_csr_num;
  logic [XLEN-1:0] in_csr_wvalue;
  logic [XLEN-1:0] in_csr_wmask;
  logic            in_ex;
  logic [5:0]      in_ecode;
  logic [8:0]      in_esubcode;
  logic            in_ertn;

  modport master (
    output in_valid, in_pc, in_gr_we, in_dest,
    output in_result, in_csr_we, in_csr_num,
    output in_csr_wvalue, in_csr_wmask,
    output in_ex, in_ecode, in_esubcode, in_ertn,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_gr_we, in_dest,
    input  in_result, in_csr_we, in_csr_num,
    input  in_csr_wvalue, in_csr_wmask,
    input  in_ex, in_ecode, in_esubcode, in_ertn,
    output in_ready
  );
endinterface

// File: rtl/wb_retire_buffer.sv
// In-order write-back retire buffer: queues MEM results and
// commits them to GPR/CSR under trace back-pressure.
module wb_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  wb_retire_buffer_if.slave mem,
  input  logic             trace_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [XLEN-1:0]  csr_wvalue,
  output logic [XLEN-1:0]  csr_wmask,
  output logic [XLEN-1:0]  wb_pc,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic             ertn_flush,
  output logic [31:0]      pend_mask,
  output logic [4:0]       fwd_dest,
  output logic [XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]  debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [XLEN-1:0]  debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] result;
    logic            csr_we;
    logic [13:0]     csr_num;
    logic [XLEN-1:0] csr_wvalue;
    logic [XLEN-1:0] csr_wmask;
    logic            ex;
    logic [5:0]      ecode;
    logic [8:0]      esubcode;
    logic            ertn;
  } entry_t;

  entry_t            buf_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  ret_q;

  entry_t in_e;
  entry_t head;
  logic   head_vld;
  logic   full;
  logic   retire;
  logic   flush;
  logic   push;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    in_e            = '0;
    in_e.pc         = mem.in_pc;
    in_e.gr_we      = mem.in_gr_we;
    in_e.dest       = mem.in_dest;
    in_e.result     = mem.in_result;
    in_e.csr_we     = mem.in_csr_we;
    in_e.csr_num    = mem.in_csr_num;
    in_e.csr_wvalue = mem.in_csr_wvalue;
    in_e.csr_wmask  = mem.in_csr_wmask;
    in_e.ex         = mem.in_ex;
    in_e.ecode      = mem.in_ecode;
    in_e.esubcode   = mem.in_esubcode;
    in_e.ertn       = mem.in_ertn;
  end

  assign head_vld = (cnt_q != '0);
  assign head     = head_vld ? buf_q[rd_ptr] : '0;
  assign full     = (cnt_q == CW'(DEPTH));
  // Nothing commits while reset is held, even if entries remain.
  assign retire   = resetn && head_vld && trace_ready;
  assign flush    = retire && (head.ex || head.ertn);
  assign mem.in_ready = (!full || retire) && !flush;
  assign push     = mem.in_valid && mem.in_ready;

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (retire) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= inc_ptr(rd_ptr);
      end
      // Set after the clear so a full push+pop keeps the slot live.
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= inc_ptr(wr_ptr);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) ret_q <= '0;
    else if (retire && !head.ex) ret_q <= ret_q + CNT_W'(1);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && buf_q[i].gr_we && !buf_q[i].ex)
        pend_mask[buf_q[i].dest] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign rf_we      = retire && head.gr_we && !head.ex && !head.ertn;
  assign csr_we     = retire && head.csr_we && !head.ex && !head.ertn;
  assign rf_waddr   = head.dest;
  assign rf_wdata   = head.result;
  assign csr_num    = head.csr_num;
  assign csr_wvalue = head.csr_wvalue;
  assign csr_wmask  = head.csr_wmask;
  assign wb_pc      = head.pc;
  assign wb_ex      = retire && head.ex;
  assign wb_ecode   = head.ecode;
  assign wb_esubcode = head.esubcode;
  assign ertn_flush = retire && head.ertn && !head.ex;

  assign fwd_dest = (head_vld && head.gr_we && !head.ex) ? head.dest : 5'd0;
  assign fwd_data = head.result;

  assign debug_wb_pc       = head.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = head.dest;
  assign debug_wb_rf_wdata = head.result;
  assign retire_cnt        = ret_q;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed bench for wb_retire_buffer (DEPTH=2, CNT_W=4).
module tb_wb_retire_buffer;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic trace_ready = 1'b0;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            csr_we;
  logic [13:0]     csr_num;
  logic [XLEN-1:0] csr_wvalue;
  logic [XLEN-1:0] csr_wmask;
  logic [XLEN-1:0] wb_pc;
  logic            wb_ex;
  logic [5:0]      wb_ecode;
  logic [8:0]      wb_esubcode;
  logic            ertn_flush;
  logic [31:0]     pend_mask;
  logic [4:0]      fwd_dest;
  logic [XLEN-1:0] fwd_data;
  logic [XLEN-1:0] debug_wb_pc;
  logic [3:0]      debug_wb_rf_we;
  logic [4:0]      debug_wb_rf_wnum;
  logic [XLEN-1:0] debug_wb_rf_wdata;
  logic [CNT_W-1:0] retire_cnt;

  int total = 0;
  int fails = 0;

  wb_retire_buffer_if #(.XLEN(XLEN)) ifc ();

  wb_retire_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .mem(ifc),
    .trace_ready(trace_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_num(csr_num),
    .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
    .wb_pc(wb_pc), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .ertn_flush(ertn_flush),
    .pend_mask(pend_mask), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_valid      = 1'b0;
    ifc.in_pc         = '0;
    ifc.in_gr_we      = 1'b0;
    ifc.in_dest       = '0;
    ifc.in_result     = '0;
    ifc.in_csr_we     = 1'b0;
    ifc.in_csr_num    = '0;
    ifc.in_csr_wvalue = '0;
    ifc.in_csr_wmask  = '0;
    ifc.in_ex         = 1'b0;
    ifc.in_ecode      = '0;
    ifc.in_esubcode   = '0;
    ifc.in_ertn       = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic gw,
                       input logic [4:0] dst, input logic [31:0] res);
    idle();
    ifc.in_valid  = 1'b1;
    ifc.in_pc     = pc;
    ifc.in_gr_we  = gw;
    ifc.in_dest   = dst;
    ifc.in_result = res;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_wb_ex", wb_ex, 0);
    chk("rst_ertn", ertn_flush, 0);
    chk("rst_fwd", fwd_dest, 0);
    chk("rst_wb_pc", wb_pc, 0);

    // single entry, immediate retire
    tick();
    trace_ready = 1'b1;
    drive(32'h1c00_0000, 1'b1, 5'd5, 32'hDEAD);
    @(negedge clk);
    chk("a_ready", ifc.in_ready, 1);
    chk("a_latency", rf_we, 0);
    tick();
    idle();
    @(negedge clk);
    chk("a_rf_we", rf_we, 1);
    chk("a_waddr", rf_waddr, 5);
    chk("a_wdata", rf_wdata, 32'hDEAD);
    chk("a_dbg_we", debug_wb_rf_we, 4'hF);
    chk("a_pc", wb_pc, 32'h1c00_0000);
    chk("a_dbg_pc", debug_wb_pc, 32'h1c00_0000);
    chk("a_fwd", fwd_dest, 5);
    chk("a_pend", pend_mask, 32'h20);
    tick();
    @(negedge clk);
    chk("a_cnt", retire_cnt, 1);
    chk("a_idle_we", rf_we, 0);

    // back-pressure, fill, then in-order drain with push at full
    tick();
    trace_ready = 1'b0;
    drive(32'h100, 1'b1, 5'd1, 32'h11);
    tick();
    drive(32'h104, 1'b1, 5'd2, 32'h22);
    @(negedge clk);
    chk("b_ready1", ifc.in_ready, 1);
    tick();
    drive(32'h108, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    chk("b_full_ready", ifc.in_ready, 0);
    chk("b_pend", pend_mask, 32'h6);
    chk("b_hold_we", rf_we, 0);
    #1;
    trace_ready = 1'b1;
    #1;
    chk("b_ready_ret", ifc.in_ready, 1);
    chk("b_ret1_we", rf_we, 1);
    chk("b_ret1_addr", rf_waddr, 1);
    chk("b_ret1_data", rf_wdata, 32'h11);
    tick();
    idle();
    @(negedge clk);
    chk("b_ret2_addr", rf_waddr, 2);
    chk("b_ret2_data", rf_wdata, 32'h22);
    chk("b_pend2", pend_mask, 32'hC);
    tick();
    @(negedge clk);
    chk("b_ret3_addr", rf_waddr, 3);
    chk("b_ret3_data", rf_wdata, 32'h33);
    chk("b_ret3_pc", wb_pc, 32'h108);
    tick();
    @(negedge clk);
    chk("b_empty_we", rf_we, 0);
    chk("b_cnt", retire_cnt, 4);

    // exception at head flushes a younger entry
    trace_ready = 1'b0;
    drive(32'h200, 1'b1, 5'd7, 32'h77);
    ifc.in_ex = 1'b1;
    ifc.in_ecode = 6'h0B;
    ifc.in_esubcode = 9'h3;
    tick();
    drive(32'h204, 1'b1, 5'd8, 32'h88);
    @(negedge clk);
    chk("c_pend_ex", pend_mask, 0);
    chk("c_fwd_ex", fwd_dest, 0);
    tick();
    idle();
    @(negedge clk);
    chk("c_pend_young", pend_mask, 32'h100);
    #1;
    trace_ready = 1'b1;
    #1;
    chk("c_wb_ex", wb_ex, 1);
    chk("c_rf_we", rf_we, 0);
    chk("c_ecode", wb_ecode, 6'h0B);
    chk("c_esub", wb_esubcode, 9'h3);
    chk("c_ready", ifc.in_ready, 0);
    tick();
    @(negedge clk);
    chk("c_post_we", rf_we, 0);
    chk("c_post_ex", wb_ex, 0);
    chk("c_post_pc", wb_pc, 0);
    chk("c_post_ready", ifc.in_ready, 1);
    chk("c_cnt", retire_cnt, 4);

    // ERTN with csr write; concurrent offer is dropped
    trace_ready = 1'b0;
    drive(32'h300, 1'b0, 5'd0, 32'h0);
    ifc.in_ertn = 1'b1;
    ifc.in_csr_we = 1'b1;
    ifc.in_csr_num = 14'h6;
    ifc.in_csr_wvalue = 32'h55;
    ifc.in_csr_wmask = 32'hFFFF_FFFF;
    tick();
    drive(32'h400, 1'b1, 5'd9, 32'h99);
    #1;
    trace_ready = 1'b1;
    @(negedge clk);
    chk("d_ertn", ertn_flush, 1);
    chk("d_csr_we", csr_we, 0);
    chk("d_wb_ex", wb_ex, 0);
    chk("d_ready", ifc.in_ready, 0);
    chk("d_csr_num", csr_num, 14'h6);
    tick();
    idle();
    @(negedge clk);
    chk("d_empty_pc", wb_pc, 0);
    chk("d_no_push", rf_we, 0);
    chk("d_cnt", retire_cnt, 5);

    // plain CSR write
    drive(32'h500, 1'b0, 5'd0, 32'h0);
    ifc.in_csr_we = 1'b1;
    ifc.in_csr_num = 14'h180;
    ifc.in_csr_wvalue = 32'h1234;
    ifc.in_csr_wmask = 32'hFF;
    tick();
    idle();
    @(negedge clk);
    chk("e_csr_we", csr_we, 1);
    chk("e_csr_num", csr_num, 14'h180);
    chk("e_csr_val", csr_wvalue, 32'h1234);
    chk("e_csr_mask", csr_wmask, 32'hFF);
    chk("e_rf_we", rf_we, 0);
    tick();
    @(negedge clk);
    chk("e_cnt", retire_cnt, 6);

    // reset mid-stream, dest 0 never pending
    trace_ready = 1'b0;
    drive(32'h600, 1'b1, 5'd0, 32'h66);
    tick();
    drive(32'h604, 1'b1, 5'd4, 32'h44);
    tick();
    idle();
    @(negedge clk);
    chk("f_pend", pend_mask, 32'h10);
    chk("f_full", ifc.in_ready, 0);
    #1;
    resetn = 1'b0;
    trace_ready = 1'b1;
    #1;
    chk("f_rst_we", rf_we, 0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("f_post_we", rf_we, 0);
    chk("f_post_ready", ifc.in_ready, 1);
    chk("f_post_pend", pend_mask, 0);
    chk("f_post_cnt", retire_cnt, 0);

    // counter wrap at CNT_W=4
    for (int i = 0; i < 17; i++) begin
      drive(32'h700 + 32'(i * 4), 1'b1, 5'd10, 32'(i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("g_cnt16", retire_cnt, 0);
    chk("g_last_data", rf_wdata, 16);
    tick();
    @(negedge clk);
    chk("g_cnt17", retire_cnt, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
